// File: rtl/xcpt_seq_pkg.sv
// Shared encodings for the machine-mode trap entry sequencer: FSM states,
// trap CSR addresses and mtvec mode values.
package xcpt_seq_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR_EPC   = 3'd1;
  localparam logic [2:0] ST_WR_CAUSE = 3'd2;
  localparam logic [2:0] ST_WR_TVAL  = 3'd3;
  localparam logic [2:0] ST_FLUSH    = 3'd4;
  localparam logic [2:0] ST_REDIRECT = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    WR_EPC   = ST_WR_EPC,
    WR_CAUSE = ST_WR_CAUSE,
    WR_TVAL  = ST_WR_TVAL,
    FLUSH    = ST_FLUSH,
    REDIRECT = ST_REDIRECT
  } state_t;

  localparam logic [11:0] MEPC   = 12'h341;
  localparam logic [11:0] MCAUSE = 12'h342;
  localparam logic [11:0] MTVAL  = 12'h343;

  localparam logic [1:0] DIRECT   = 2'd0;
  localparam logic [1:0] VECTORED = 2'd1;

endpackage

// File: rtl/xcpt_trap_sequencer_if.sv
// Bundle of the commit-side exception inputs, the CSR write port, the flush
// handshake and the fetch redirect strobe around the trap sequencer.
interface xcpt_trap_sequencer_if #(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 8
);
  // Handshakes: csr_wr_req_o / flush_req_o stay high with stable payload until
  // the matching ack is sampled high on a rising edge; an ack with no request
  // pending is ignored. redirect_valid_o is a single-cycle strobe, no ack.
  logic [NUM_SRC-1:0]      xcpt_valid_i;
  logic [NUM_SRC*XLEN-1:0] xcpt_cause_i;
  logic [NUM_SRC*XLEN-1:0] xcpt_tval_i;
  logic [XLEN-1:0]         xcpt_pc_i;
  logic [XLEN-1:0]         mtvec_i;
  logic                    busy_o;
  logic                    csr_wr_req_o;
  logic [11:0]             csr_wr_addr_o;
  logic [XLEN-1:0]         csr_wr_data_o;
  logic                    csr_wr_ack_i;
  logic                    flush_req_o;
  logic                    flush_ack_i;
  logic                    redirect_valid_o;
  logic [XLEN-1:0]         redirect_pc_o;

  modport master (
    input  xcpt_valid_i, xcpt_cause_i, xcpt_tval_i, xcpt_pc_i, mtvec_i,
    input  csr_wr_ack_i, flush_ack_i,
    output busy_o, csr_wr_req_o, csr_wr_addr_o, csr_wr_data_o,
    output flush_req_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    output xcpt_valid_i, xcpt_cause_i, xcpt_tval_i, xcpt_pc_i, mtvec_i,
    output csr_wr_ack_i, flush_ack_i,
    input  busy_o, csr_wr_req_o, csr_wr_addr_o, csr_wr_data_o,
    input  flush_req_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/xcpt_prio_sel.sv
// Fixed-priority exception selector: the lowest-index valid source wins;
// all outputs are zero when nothing is valid.
module xcpt_prio_sel #(
  parameter int NUM_SRC = 8,
  parameter int XLEN    = 64
) (
  input  logic [NUM_SRC-1:0]      valid,
  input  logic [NUM_SRC*XLEN-1:0] cause,
  input  logic [NUM_SRC*XLEN-1:0] tval,
  output logic                    any_valid,
  output logic [XLEN-1:0]         sel_cause,
  output logic [XLEN-1:0]         sel_tval
);

  // Scan from the top down so the lowest asserted index is written last.
  always_comb begin
    any_valid = |valid;
    sel_cause = '0;
    sel_tval  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (valid[i]) begin
        sel_cause = cause[i*XLEN +: XLEN];
        sel_tval  = tval[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/xcpt_trap_sequencer.sv
// Machine-mode trap entry: latch the winning exception, write mepc/mcause/mtval
// over the shared CSR port, flush the pipeline, then redirect fetch to mtvec.
module xcpt_trap_sequencer
  import xcpt_seq_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  xcpt_trap_sequencer_if.master bus,
  output state_t                dbg_state_o
);

  state_t          state_q;
  logic [XLEN-1:0] pc_q, cause_q, tval_q;
  logic            csr_req_q, flush_req_q, redirect_valid_q;
  logic [11:0]     csr_addr_q;
  logic [XLEN-1:0] csr_data_q, redirect_pc_q;

  logic            any_valid;
  logic [XLEN-1:0] sel_cause, sel_tval;
  logic [XLEN-1:0] vec_base, vec_off, trap_target;

  xcpt_prio_sel #(.NUM_SRC(NUM_SRC), .XLEN(XLEN)) u_prio_sel (
    .valid     (bus.xcpt_valid_i),
    .cause     (bus.xcpt_cause_i),
    .tval      (bus.xcpt_tval_i),
    .any_valid (any_valid),
    .sel_cause (sel_cause),
    .sel_tval  (sel_tval)
  );

  // Vectored mode only offsets interrupts; the shift drops the top cause bits.
  assign vec_base    = {bus.mtvec_i[XLEN-1:2], 2'b00};
  assign vec_off     = {cause_q[XLEN-3:0], 2'b00};
  assign trap_target = (bus.mtvec_i[1:0] == VECTORED && cause_q[XLEN-1])
                       ? vec_base + vec_off : vec_base;

  // The target is registered on the flush-ack edge so the redirect strobe
  // leaves a flop rather than a combinational path from mtvec_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q          <= IDLE;
      pc_q             <= '0;
      cause_q          <= '0;
      tval_q           <= '0;
      csr_req_q        <= 1'b0;
      csr_addr_q       <= '0;
      csr_data_q       <= '0;
      flush_req_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            pc_q       <= bus.xcpt_pc_i;
            cause_q    <= sel_cause;
            tval_q     <= sel_tval;
            csr_req_q  <= 1'b1;
            csr_addr_q <= MEPC;
            csr_data_q <= bus.xcpt_pc_i;
            state_q    <= WR_EPC;
          end
        end
        WR_EPC: begin
          if (bus.csr_wr_ack_i) begin
            csr_addr_q <= MCAUSE;
            csr_data_q <= cause_q;
            state_q    <= WR_CAUSE;
          end
        end
        WR_CAUSE: begin
          if (bus.csr_wr_ack_i) begin
            csr_addr_q <= MTVAL;
            csr_data_q <= tval_q;
            state_q    <= WR_TVAL;
          end
        end
        WR_TVAL: begin
          if (bus.csr_wr_ack_i) begin
            csr_req_q   <= 1'b0;
            csr_addr_q  <= '0;
            csr_data_q  <= '0;
            flush_req_q <= 1'b1;
            state_q     <= FLUSH;
          end
        end
        FLUSH: begin
          if (bus.flush_ack_i) begin
            flush_req_q      <= 1'b0;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= trap_target;
            state_q          <= REDIRECT;
          end
        end
        REDIRECT: begin
          redirect_valid_q <= 1'b0;
          redirect_pc_q    <= '0;
          state_q          <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o           = (state_q != IDLE);
  assign bus.csr_wr_req_o     = csr_req_q;
  assign bus.csr_wr_addr_o    = csr_addr_q;
  assign bus.csr_wr_data_o    = csr_data_q;
  assign bus.flush_req_o      = flush_req_q;
  assign bus.redirect_valid_o = redirect_valid_q;
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_xcpt_trap_sequencer.sv
// Directed bench for the trap sequencer: cycle-exact checks of the trap entry
// sequence plus a scoreboard of accepted CSR writes and redirect targets.
module tb_xcpt_trap_sequencer;
  import xcpt_seq_pkg::*;

  localparam int XLEN    = 64;
  localparam int NUM_SRC = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  xcpt_trap_sequencer_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) bus ();
  state_t dbg_state;

  xcpt_trap_sequencer #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // {addr, data} of each CSR write expected to be accepted, in order.
  logic [75:0] exp_q[$];
  logic [63:0] exp_rd_q[$];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [63:0] cause, input logic [63:0] tval);
    bus.xcpt_cause_i[k*XLEN +: XLEN] = cause;
    bus.xcpt_tval_i[k*XLEN +: XLEN]  = tval;
  endtask

  // Holds the request for one cycle (cycle N); returns at the start of N+1.
  task automatic pulse(input logic [NUM_SRC-1:0] mask, input logic [63:0] pc);
    bus.xcpt_valid_i = mask;
    bus.xcpt_pc_i    = pc;
    tick();
    bus.xcpt_valid_i = '0;
  endtask

  task automatic expect_trap(input logic [63:0] pc, input logic [63:0] cause,
                             input logic [63:0] tval, input logic [63:0] rd);
    exp_q.push_back({12'h341, pc});
    exp_q.push_back({12'h342, cause});
    exp_q.push_back({12'h343, tval});
    exp_rd_q.push_back(rd);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && bus.busy_o; i++) tick();
    chk(tag, {79'd0, bus.busy_o}, 80'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.csr_wr_req_o && bus.csr_wr_ack_i) begin
        if (exp_q.size() == 0)
          chk("sb_unexpected_wr", {4'd0, bus.csr_wr_addr_o, bus.csr_wr_data_o}, 80'd0);
        else
          chk("sb_csr_wr", {4'd0, bus.csr_wr_addr_o, bus.csr_wr_data_o}, {4'd0, exp_q.pop_front()});
      end
      if (bus.redirect_valid_o) begin
        if (exp_rd_q.size() == 0)
          chk("sb_unexpected_rd", {16'd0, bus.redirect_pc_o}, {16'hFFFF, 64'd0});
        else
          chk("sb_redirect", {16'd0, bus.redirect_pc_o}, {16'd0, exp_rd_q.pop_front()});
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rstn             = 1'b0;
    bus.xcpt_valid_i = '0;
    bus.xcpt_cause_i = '0;
    bus.xcpt_tval_i  = '0;
    bus.xcpt_pc_i    = '0;
    bus.mtvec_i      = 64'h8000_0000;
    bus.csr_wr_ack_i = 1'b1;
    bus.flush_ack_i  = 1'b1;
    tick();
    tick();
    chk("rst_csr", {3'd0, bus.csr_wr_req_o, bus.csr_wr_addr_o, bus.csr_wr_data_o}, 80'd0);
    chk("rst_misc", {77'd0, bus.busy_o, bus.flush_req_o, bus.redirect_valid_o}, 80'd0);
    chk("rst_state", {77'd0, dbg_state}, {77'd0, ST_IDLE});
    @(negedge clk) rstn = 1'b1;
    tick();

    // T1: single source 5, zero-wait acks, cycle-exact timeline.
    set_src(5, 64'h5, 64'hDEAD);
    expect_trap(64'h8000_1000, 64'h5, 64'hDEAD, 64'h8000_0000);
    chk("t1_idle_n", {79'd0, bus.busy_o}, 80'd0);
    pulse(8'h20, 64'h8000_1000);
    chk("t1_epc", {3'd0, bus.csr_wr_req_o, bus.csr_wr_addr_o, bus.csr_wr_data_o},
        {3'd0, 1'b1, 12'h341, 64'h8000_1000});
    chk("t1_busy", {79'd0, bus.busy_o}, 80'd1);
    tick();
    chk("t1_cause", {3'd0, bus.csr_wr_req_o, bus.csr_wr_addr_o, bus.csr_wr_data_o},
        {3'd0, 1'b1, 12'h342, 64'h5});
    tick();
    chk("t1_tval", {3'd0, bus.csr_wr_req_o, bus.csr_wr_addr_o, bus.csr_wr_data_o},
        {3'd0, 1'b1, 12'h343, 64'hDEAD});
    tick();
    chk("t1_flush", {78'd0, bus.flush_req_o, bus.csr_wr_req_o}, 80'd2);
    chk("t1_csr_zero", {4'd0, bus.csr_wr_addr_o, bus.csr_wr_data_o}, 80'd0);
    tick();
    chk("t1_redirect", {15'd0, bus.redirect_valid_o, bus.redirect_pc_o},
        {15'd0, 1'b1, 64'h8000_0000});
    chk("t1_flush_drop", {79'd0, bus.flush_req_o}, 80'd0);
    tick();
    chk("t1_done", {14'd0, bus.busy_o, bus.redirect_valid_o, bus.redirect_pc_o}, 80'd0);
    set_src(5, 64'h0, 64'h0);

    // T2: sources 2, 3, 7 together; source 2 wins.
    set_src(2, 64'h2, 64'h222);
    set_src(3, 64'h3, 64'h333);
    set_src(7, 64'h7, 64'h777);
    expect_trap(64'h4000, 64'h2, 64'h222, 64'h8000_0000);
    pulse(8'h8C, 64'h4000);
    wait_idle("t2_idle");
    bus.xcpt_cause_i = '0;
    bus.xcpt_tval_i  = '0;

    // T3: vectored interrupt, then the same cause with mode 2.
    bus.mtvec_i = 64'h8000_0001;
    set_src(0, 64'h8000_0000_0000_0007, 64'h11);
    expect_trap(64'h5000, 64'h8000_0000_0000_0007, 64'h11, 64'h8000_001C);
    pulse(8'h01, 64'h5000);
    repeat (4) tick();
    chk("t3_vec_pc", {15'd0, bus.redirect_valid_o, bus.redirect_pc_o},
        {15'd0, 1'b1, 64'h8000_001C});
    wait_idle("t3_idle_a");
    bus.mtvec_i = 64'h8000_0002;
    expect_trap(64'h5004, 64'h8000_0000_0000_0007, 64'h11, 64'h8000_0000);
    pulse(8'h01, 64'h5004);
    wait_idle("t3_idle_b");

    // T4: ack withheld for 4 cycles in WR_CAUSE.
    bus.mtvec_i = 64'h8000_0000;
    set_src(1, 64'h2, 64'hBEEF);
    expect_trap(64'h6000, 64'h2, 64'hBEEF, 64'h8000_0000);
    pulse(8'h02, 64'h6000);
    tick();
    bus.csr_wr_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_stall", {3'd0, bus.csr_wr_req_o, bus.csr_wr_addr_o, bus.csr_wr_data_o},
          {3'd0, 1'b1, 12'h342, 64'h2});
      tick();
    end
    bus.csr_wr_ack_i = 1'b1;
    chk("t4_ack_cycle", {68'd0, bus.csr_wr_addr_o}, {68'd0, 12'h342});
    tick();
    chk("t4_tval", {3'd0, bus.csr_wr_req_o, bus.csr_wr_addr_o, bus.csr_wr_data_o},
        {3'd0, 1'b1, 12'h343, 64'hBEEF});
    tick();
    tick();
    chk("t4_late_redirect", {79'd0, bus.redirect_valid_o}, 80'd1);
    wait_idle("t4_idle");

    // T5: request pulsed during FLUSH is dropped.
    set_src(4, 64'h4, 64'h44);
    set_src(6, 64'h6, 64'h66);
    expect_trap(64'h7000, 64'h4, 64'h44, 64'h8000_0000);
    pulse(8'h10, 64'h7000);
    repeat (3) tick();
    chk("t5_in_flush", {79'd0, bus.flush_req_o}, 80'd1);
    pulse(8'h40, 64'h7777);
    chk("t5_redirect", {79'd0, bus.redirect_valid_o}, 80'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_stays_idle", {79'd0, bus.busy_o}, 80'd0);
    end

    // T6: reset asserted mid-WR_TVAL with the ack withheld.
    set_src(3, 64'h33, 64'h3333);
    exp_q.push_back({12'h341, 64'h9000});
    exp_q.push_back({12'h342, 64'h33});
    pulse(8'h08, 64'h9000);
    tick();
    tick();
    bus.csr_wr_ack_i = 1'b0;
    chk("t6_in_tval", {3'd0, bus.csr_wr_req_o, bus.csr_wr_addr_o, bus.csr_wr_data_o},
        {3'd0, 1'b1, 12'h343, 64'h3333});
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_csr", {3'd0, bus.csr_wr_req_o, bus.csr_wr_addr_o, bus.csr_wr_data_o}, 80'd0);
    chk("t6_rst_misc", {14'd0, bus.busy_o, bus.flush_req_o, bus.redirect_valid_o, bus.redirect_pc_o}, 80'd0);
    chk("t6_rst_state", {77'd0, dbg_state}, {77'd0, ST_IDLE});
    tick();
    @(negedge clk) rstn = 1'b1;
    bus.csr_wr_ack_i = 1'b1;
    tick();
    chk("t6_post_idle", {79'd0, bus.busy_o}, 80'd0);
    set_src(0, 64'h1, 64'h10);
    expect_trap(64'hA000, 64'h1, 64'h10, 64'h8000_0000);
    pulse(8'h01, 64'hA000);
    chk("t6_recapture", {3'd0, bus.csr_wr_req_o, bus.csr_wr_addr_o, bus.csr_wr_data_o},
        {3'd0, 1'b1, 12'h341, 64'hA000});
    wait_idle("t6_idle");

    tick();
    chk("sb_wr_drained", 80'(exp_q.size()), 80'd0);
    chk("sb_rd_drained", 80'(exp_rd_q.size()), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
